// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO read-side stream master.
// Contents: default widths and the reader state encoding.
package fifo_pkg;

    localparam int DATA_WIDTH_DFLT = 8;
    localparam int CNT_WIDTH_DFLT  = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } rd_state_t;

endpackage

// File: rtl/fifo_rd_skid.sv
// Two-entry in-order buffer that holds words returned by the FIFO until the
// stream consumer takes them. Entry 0 is always the head.
// Ports:
//   i_clk, i_rst    clock, async active-high reset
//   i_push, i_data  store i_data behind the existing entries
//   i_pop           drop the head entry
//   i_clear         drop all entries (has priority over push/pop)
//   o_head          oldest stored word
//   o_occ           number of stored words (0..2)
module fifo_rd_skid
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DFLT
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_push,
    input  logic                  i_pop,
    input  logic                  i_clear,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic [DATA_WIDTH-1:0] o_head,
    output logic [1:0]            o_occ
);

    logic [DATA_WIDTH-1:0] r_ent0;
    logic [DATA_WIDTH-1:0] r_ent1;
    logic [1:0]            r_occ;

    // The caller never pushes into a full buffer and never pops an empty one.
    // r_ent0 only changes when the head is consumed or the buffer was empty,
    // so the presented word stays stable until it is taken.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ent0 <= '0;
            r_ent1 <= '0;
            r_occ  <= 2'd0;
        end else if (i_clear) begin
            r_occ <= 2'd0;
        end else begin
            case ({i_push, i_pop})
                2'b10: begin
                    if (r_occ == 2'd0) r_ent0 <= i_data;
                    else               r_ent1 <= i_data;
                    r_occ <= r_occ + 2'd1;
                end
                2'b01: begin
                    r_ent0 <= r_ent1;
                    r_occ  <= r_occ - 2'd1;
                end
                2'b11: begin
                    if (r_occ == 2'd1) begin
                        r_ent0 <= i_data;
                    end else begin
                        r_ent0 <= r_ent1;
                        r_ent1 <= i_data;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_head = r_ent0;
    assign o_occ  = r_occ;

endmodule

// File: rtl/fifo_stream_reader.sv
// Read-side master for a synchronous FIFO with one cycle of read latency.
// Pops words with o_fifo_rd_en and presents them on a valid/ready stream,
// sustaining one word per cycle while the consumer is ready.
// Ports:
//   i_clk, i_rst        clock, async active-high reset
//   i_en                1 = keep reading, 0 = stop issuing and drain
//   i_flush             discard buffered and returning words
//   i_fifo_empty        FIFO empty flag
//   i_fifo_data_out     FIFO read data, valid the cycle after a pop
//   o_fifo_rd_en        FIFO pop request
//   o_m_valid, o_m_data output stream (o_m_data = oldest buffered word)
//   i_m_ready           consumer ready
//   o_busy              reader active or holding/awaiting words
//   o_word_count        accepted handshakes, wraps silently
//
// state | meaning
// IDLE  | no reads issued, nothing buffered or in flight
// RUN   | issuing reads while buffer room and FIFO data allow
// STOP  | no new reads; finishing in-flight word and draining buffer
module fifo_stream_reader
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DFLT,
    parameter int CNT_WIDTH  = CNT_WIDTH_DFLT
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_en,
    input  logic                  i_flush,
    input  logic                  i_fifo_empty,
    input  logic [DATA_WIDTH-1:0] i_fifo_data_out,
    output logic                  o_fifo_rd_en,
    output logic                  o_m_valid,
    output logic [DATA_WIDTH-1:0] o_m_data,
    input  logic                  i_m_ready,
    output logic                  o_busy,
    output logic [CNT_WIDTH-1:0]  o_word_count
);

    rd_state_t            r_state;
    rd_state_t            w_state_next;
    logic                 r_inflight;
    logic [CNT_WIDTH-1:0] r_word_count;
    logic [1:0]           w_occ;
    logic [2:0]           w_level;
    logic                 w_pop;
    logic                 w_handshake;
    logic                 w_push;
    logic                 w_rd_en;

    assign o_m_valid   = (w_occ != 2'd0);
    assign w_pop       = o_m_valid & i_m_ready;
    // A flush cancels the presented word, so it is neither consumed nor counted.
    assign w_handshake = w_pop & ~i_flush;
    // The word returning from a read issued last cycle is dropped on flush.
    assign w_push      = r_inflight & ~i_flush;
    // Entries committed after this edge, before any pop: buffered plus returning.
    assign w_level     = {1'b0, w_occ} + {2'b00, r_inflight};

    fifo_rd_skid #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (w_push),
        .i_pop   (w_handshake),
        .i_clear (i_flush),
        .i_data  (i_fifo_data_out),
        .o_head  (o_m_data),
        .o_occ   (w_occ)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= IDLE;
            r_inflight   <= 1'b0;
            r_word_count <= '0;
        end else begin
            r_state    <= w_state_next;
            r_inflight <= w_rd_en;
            if (w_handshake) r_word_count <= r_word_count + 1'b1;
        end
    end

    always_comb begin
        w_state_next = r_state;
        // A read is allowed only if its word is guaranteed a buffer slot when it returns.
        w_rd_en      = (r_state == RUN) & i_en & ~i_fifo_empty & ~i_flush &
                       (w_level < (3'd2 + {2'b00, w_pop}));
        case (r_state)
            IDLE:    if (i_en) w_state_next = RUN;
            RUN:     if (!i_en) w_state_next = STOP;
            STOP: begin
                if (i_en)                                      w_state_next = RUN;
                else if (!r_inflight && (w_occ == 2'd0))       w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    assign o_fifo_rd_en = w_rd_en;
    assign o_busy       = (r_state != IDLE) | (w_occ != 2'd0) | r_inflight;
    assign o_word_count = r_word_count;

endmodule

// File: tb/tb_fifo_stream_reader.sv
module tb_fifo_stream_reader;

    localparam int DW = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          flush;
    logic          fifo_empty;
    logic [DW-1:0] fifo_data_out;
    logic          fifo_rd_en;
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic          m_ready;
    logic          busy;
    logic [CW-1:0] word_count;

    always #5 clk = ~clk;

    fifo_stream_reader #(
        .DATA_WIDTH (DW),
        .CNT_WIDTH  (CW)
    ) dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_en            (en),
        .i_flush         (flush),
        .i_fifo_empty    (fifo_empty),
        .i_fifo_data_out (fifo_data_out),
        .o_fifo_rd_en    (fifo_rd_en),
        .o_m_valid       (m_valid),
        .o_m_data        (m_data),
        .i_m_ready       (m_ready),
        .o_busy          (busy),
        .o_word_count    (word_count)
    );

    // Reference model: the FIFO contents, and the words popped but not yet
    // delivered, each tagged with the cycle from which it may be presented.
    typedef struct {
        logic [DW-1:0] d;
        int            vis;
    } ent_t;

    logic [DW-1:0] fifo_q[$];
    ent_t          exp_q[$];
    int            cyc;
    int            model_cnt;
    bit            m_run;
    bit            m_idle;
    int            hs_total;
    int            first_hs;
    int            last_hs;
    int            rd_dut_total;
    bit            last_rd;
    int            n_checks;
    int            n_fail;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic push_word(input logic [DW-1:0] w);
        fifo_q.push_back(w);
        fifo_empty = 1'b0;
    endtask

    // Called at posedge+1 with inputs already set; returns at the next posedge+1.
    task automatic tick();
        bit            hs;
        bit            exp_valid;
        bit            exp_rd;
        int            sz;
        logic [DW-1:0] w;
        @(negedge clk);
        sz        = exp_q.size();
        exp_valid = (sz > 0) && (exp_q[0].vis <= cyc);
        check_eq("m_valid", m_valid, exp_valid);
        if (exp_valid) check_eq("m_data", m_data, exp_q[0].d);
        hs     = exp_valid & m_ready & ~flush;
        exp_rd = m_run & en & (fifo_q.size() != 0) & ~flush & ((sz - int'(hs)) < 2);
        check_eq("rd_en", fifo_rd_en, exp_rd);
        check_eq("busy", busy, (!m_idle || sz > 0));
        check_eq("word_count", word_count, 32'(model_cnt % 16));
        last_rd = fifo_rd_en;
        if (fifo_rd_en) rd_dut_total++;
        @(posedge clk);
        #1;
        if (flush) begin
            exp_q.delete();
        end else if (hs) begin
            void'(exp_q.pop_front());
            model_cnt++;
            if (hs_total == 0) first_hs = cyc;
            last_hs = cyc;
            hs_total++;
        end
        if (exp_rd) begin
            w = fifo_q.pop_front();
            exp_q.push_back('{d: w, vis: cyc + 2});
            fifo_data_out = w;
        end else begin
            fifo_data_out = DW'($urandom);
        end
        if (en) begin
            m_run  = 1'b1;
            m_idle = 1'b0;
        end else if (m_run) begin
            m_run = 1'b0;
        end else if (!m_idle && sz == 0) begin
            m_idle = 1'b1;
        end
        fifo_empty = (fifo_q.size() == 0);
        cyc++;
    endtask

    // Asserts reset between clock edges and checks the outputs respond at once.
    task automatic do_reset();
        en      = 1'b0;
        flush   = 1'b0;
        m_ready = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check_eq("rst_rd_en", fifo_rd_en, 0);
        check_eq("rst_m_valid", m_valid, 0);
        check_eq("rst_m_data", m_data, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_word_count", word_count, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        model_cnt    = 0;
        m_run        = 1'b0;
        m_idle       = 1'b1;
        hs_total     = 0;
        rd_dut_total = 0;
        fifo_empty   = (fifo_q.size() == 0);
    endtask

    int  disc;
    int  cnt0;
    bit  seen;

    initial begin
        n_checks = 0; n_fail = 0; cyc = 0;
        rst = 1'b1; en = 1'b0; flush = 1'b0; m_ready = 1'b0;
        fifo_empty = 1'b1; fifo_data_out = '0;
        @(posedge clk);
        #1;
        do_reset();

        // Stream: 8 words at full rate.
        for (int i = 0; i < 8; i++) push_word(8'h11 + 8'(i));
        en = 1'b1; m_ready = 1'b1;
        repeat (16) tick();
        check_eq("stream_count", hs_total, 8);
        check_eq("stream_back2back", last_hs - first_hs, 7);
        check_eq("stream_wc", word_count, 8);
        en = 1'b0;
        repeat (3) tick();

        // Backpressure: only two reads until the consumer takes something.
        do_reset();
        for (int i = 0; i < 4; i++) push_word(8'hA0 + 8'(i));
        en = 1'b1;
        repeat (8) tick();
        check_eq("bp_rd_pulses", rd_dut_total, 2);
        check_eq("bp_valid", m_valid, 1);
        check_eq("bp_head", m_data, 8'hA0);
        m_ready = 1'b1;
        repeat (8) tick();
        check_eq("bp_delivered", hs_total, 4);

        // Stop with a read in flight: that word is delivered, the rest stay.
        do_reset();
        for (int i = 0; i < 5; i++) push_word(8'h50 + 8'(i));
        en = 1'b1; m_ready = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            tick();
            seen = last_rd;
        end
        check_eq("stop_rd_seen", seen, 1);
        en = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            tick();
            seen = !busy;
        end
        check_eq("stop_idle", busy, 0);
        check_eq("stop_delivered", hs_total, 1);
        check_eq("stop_fifo_left", fifo_q.size(), 4);
        fifo_q.delete();
        fifo_empty = 1'b1;

        // Flush with buffered and in-flight words.
        do_reset();
        for (int i = 0; i < 8; i++) push_word(8'hC0 + 8'(i));
        en = 1'b1;
        repeat (5) tick();
        m_ready = 1'b1;
        tick();
        disc = exp_q.size();
        cnt0 = model_cnt;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check_eq("flush_valid_low", m_valid, 0);
        check_eq("flush_wc", word_count, 32'(cnt0 % 16));
        repeat (14) tick();
        check_eq("flush_rest", hs_total, 8 - disc);

        // Randomized traffic, long enough to wrap the counter several times.
        do_reset();
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 2) != 0 && fifo_q.size() < 16) push_word(DW'($urandom));
            en      = ($urandom_range(0, 9) != 0);
            m_ready = ($urandom_range(0, 9) < 7);
            flush   = ($urandom_range(0, 24) == 0);
            tick();
        end
        check_eq("rand_wrapped", (hs_total > 17), 1);

        // Reset in the middle of traffic, then stay quiet with en low.
        en = 1'b1; m_ready = 1'b0; flush = 1'b0;
        push_word(8'h3C); push_word(8'h3D);
        repeat (3) tick();
        do_reset();
        repeat (4) tick();
        check_eq("post_rst_no_rd", rd_dut_total, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
